// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// divider timing and a small sign helper.
package mdu_pkg;

  // Op codes carried on EX_MDOp
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;
  localparam logic [3:0] MD_MSUB  = 4'd9;
  localparam logic [3:0] MD_MSUBU = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  // 32 restoring iterations plus one sign-fixup cycle
  localparam int DIV_CYCLES = 33;
  localparam int DIV_ITERS  = DIV_CYCLES - 1;

  // Two's-complement negate when neg is set
  function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div.sv
// Iterative radix-2 restoring divider working on magnitudes. done is high
// during the sign-fixup cycle; quotient/remainder are valid while done is high.
module mdu_div
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        running;
  logic [5:0]  count;
  logic [31:0] divisor;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        neg_q;
  logic        neg_r;
  logic [32:0] trial_shift;
  logic [32:0] trial_diff;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    trial_shift = {rem, quo[31]};
    trial_diff  = trial_shift - {1'b0, divisor};
  end

  // Iteration counter: 0..31 iterate, 32 is the fixup cycle
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      running <= 1'b0;
      count   <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
    end else if (running) begin
      if (count == 6'(DIV_ITERS)) begin
        running <= 1'b0;
        count   <= '0;
      end else begin
        count <= count + 6'd1;
      end
    end
  end

  // Operand capture and one restoring step per cycle
  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; running/count qualify when they are meaningful.
    if (start) begin
      divisor <= apply_sign(b, is_signed & b[31]);
      quo     <= apply_sign(a, is_signed & a[31]);
      rem     <= '0;
      neg_q   <= is_signed & (a[31] ^ b[31]);
      neg_r   <= is_signed & a[31];
    end else if (running && count != 6'(DIV_ITERS)) begin
      if (!trial_diff[32]) begin
        rem <= trial_diff[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= trial_shift[31:0];
        quo <= {quo[30:0], 1'b0};
      end
    end
  end

  // Sign fixup applied combinationally during the final cycle
  always_comb begin
    done      = running && (count == 6'(DIV_ITERS));
    quotient  = apply_sign(quo, neg_q);
    remainder = apply_sign(rem, neg_r);
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO.
// Optional feature: define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU.
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  EX_MDOp,
  input  logic        EX_MEM1Wr,
  input  logic        flush,
  input  logic [31:0] EX_rs_data,
  input  logic [31:0] EX_rt_data,
  output logic        isbusy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CW   = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int NSTG = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

  state_t state, state_next;

  logic op_mul, op_div, op_mt, op_signed, op_acc, op_sub;
  logic issue;

  logic signed [32:0] mul_a, mul_b;
  logic               mul_acc, mul_sub;
  logic [CW-1:0]      mul_cnt;
  logic               mul_last;
  logic signed [65:0] prod_full;
  logic [63:0]        product;
  logic [63:0]        prod_stage [NSTG];
  logic [63:0]        mul_result;
  logic [63:0]        hilo_next;

  logic        div_done;
  logic [31:0] div_q, div_r;

  // Op decode and issue qualification
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    op_mul    = 1'b0;
    op_div    = 1'b0;
    op_mt     = 1'b0;
    op_signed = 1'b0;
    op_acc    = 1'b0;
    op_sub    = 1'b0;
    case (EX_MDOp)
      MD_MULT:  begin op_mul = 1'b1; op_signed = 1'b1; end
      MD_MULTU: op_mul = 1'b1;
      MD_DIV:   begin op_div = 1'b1; op_signed = 1'b1; end
      MD_DIVU:  op_div = 1'b1;
      MD_MTHI,
      MD_MTLO:  op_mt = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD:  begin op_mul = 1'b1; op_signed = 1'b1; op_acc = 1'b1; end
      MD_MADDU: begin op_mul = 1'b1; op_acc = 1'b1; end
      MD_MSUB:  begin op_mul = 1'b1; op_signed = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
      MD_MSUBU: begin op_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`endif
      default: ;
    endcase
    issue = (op_mul | op_div | op_mt) & EX_MEM1Wr & ~flush & (state == IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (issue && op_mul)      state_next = MUL;
        else if (issue && op_div) state_next = DIV;
      end
      MUL:     if (mul_last) state_next = IDLE;
      DIV:     if (div_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign isbusy = (state != IDLE);

  // Multiplier operand capture at issue
  always_ff @(posedge clk) begin
    if (issue && op_mul) begin
      mul_a   <= {op_signed & EX_rs_data[31], EX_rs_data};
      mul_b   <= {op_signed & EX_rt_data[31], EX_rt_data};
      mul_acc <= op_acc;
      mul_sub <= op_sub;
    end
  end

  // Multiply latency counter
  always_ff @(posedge clk) begin
    if (rst)                      mul_cnt <= '0;
    else if (issue && op_mul)     mul_cnt <= '0;
    else if (mul_last)            mul_cnt <= '0;
    else if (state == MUL)        mul_cnt <= mul_cnt + 1'b1;
  end

  assign mul_last  = (state == MUL) && (mul_cnt == CW'(MUL_LAT - 1));
  assign prod_full = 66'(mul_a) * 66'(mul_b);
  assign product   = prod_full[63:0];

  // Product pipeline; operands stay constant for the whole op
  always_ff @(posedge clk) begin
    prod_stage[0] <= product;
    for (int i = 1; i < NSTG; i++) prod_stage[i] <= prod_stage[i-1];
  end

  if (MUL_LAT == 1) begin : g_mul_comb
    assign mul_result = product;
  end else begin : g_mul_reg
    assign mul_result = prod_stage[NSTG-1];
  end

  // Accumulate/subtract path for the multiply-add family
  always_comb begin
    hilo_next = mul_result;
    if (mul_acc) hilo_next = mul_sub ? ({HI, LO} - mul_result) : ({HI, LO} + mul_result);
  end

  mdu_div u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (issue & op_div),
    .is_signed (op_signed),
    .a         (EX_rs_data),
    .b         (EX_rt_data),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // HI/LO update: moves at issue, results only on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      HI <= '0;
      LO <= '0;
    end else if (issue && EX_MDOp == MD_MTHI) begin
      HI <= EX_rs_data;
    end else if (issue && EX_MDOp == MD_MTLO) begin
      LO <= EX_rs_data;
    end else if (mul_last) begin
      {HI, LO} <= hilo_next;
    end else if (div_done) begin
      LO <= div_q;
      HI <= div_r;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: a driver issues ops and queues the expected
// HI/LO and busy length; a monitor pops on completion and compares.
module tb_mdu;
  import mdu_pkg::*;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  EX_MDOp;
  logic        EX_MEM1Wr;
  logic        flush;
  logic [31:0] EX_rs_data;
  logic [31:0] EX_rt_data;
  logic        isbusy;
  logic [31:0] HI;
  logic [31:0] LO;

  mdu #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .EX_MDOp    (EX_MDOp),
    .EX_MEM1Wr  (EX_MEM1Wr),
    .flush      (flush),
    .EX_rs_data (EX_rs_data),
    .EX_rt_data (EX_rt_data),
    .isbusy     (isbusy),
    .HI         (HI),
    .LO         (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy;   // -1: busy length not checked
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] ref_hi  = '0;
  logic [31:0] ref_lo  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: architectural result of one op from plain arithmetic
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input string name);
    exp_t        e;
    logic [63:0] p;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    e.busy = 0;
    e.name = name;
    case (op)
      MD_MULT: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        {ref_hi, ref_lo} = p;
        e.busy = MUL_LAT;
      end
      MD_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        {ref_hi, ref_lo} = p;
        e.busy = MUL_LAT;
      end
      MD_DIV: begin
        if (b == 0) begin
          ref_lo = a[31] ? 32'h1 : 32'hFFFF_FFFF;
          ref_hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          ref_lo = 32'h8000_0000;
          ref_hi = 32'h0;
        end else begin
          ref_lo = sa / sb;
          ref_hi = sa % sb;
        end
        e.busy = DIV_CYCLES;
      end
      MD_DIVU: begin
        if (b == 0) begin
          ref_lo = 32'hFFFF_FFFF;
          ref_hi = a;
        end else begin
          ref_lo = a / b;
          ref_hi = a % b;
        end
        e.busy = DIV_CYCLES;
      end
      MD_MTHI: ref_hi = a;
      MD_MTLO: ref_lo = a;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MSUB: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        {ref_hi, ref_lo} = (op == MD_MADD) ? ({ref_hi, ref_lo} + p) : ({ref_hi, ref_lo} - p);
        e.busy = MUL_LAT;
      end
      MD_MADDU, MD_MSUBU: begin
        p = {32'd0, a} * {32'd0, b};
        {ref_hi, ref_lo} = (op == MD_MADDU) ? ({ref_hi, ref_lo} + p) : ({ref_hi, ref_lo} - p);
        e.busy = MUL_LAT;
      end
`endif
      default: ;
    endcase
    e.hi = ref_hi;
    e.lo = ref_lo;
    return e;
  endfunction

  // Drive one op; optional hold cycles, flush at issue, mid-flight flush or reset
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name, input int hold = 0, input bit flush_issue = 1'b0,
                        input int flush_at = -1, input int rst_at = -1);
    exp_t e;
    if (flush_issue) begin
      e.hi = ref_hi; e.lo = ref_lo; e.busy = 0; e.name = name;
    end else begin
      e = model(op, a, b, name);
    end
    if (rst_at >= 0) begin
      ref_hi = '0; ref_lo = '0;
      e.hi = '0; e.lo = '0; e.busy = -1;
    end
    @(posedge clk); #1;
    EX_MDOp = op; EX_rs_data = a; EX_rt_data = b; EX_MEM1Wr = 1'b0;
    repeat (hold) begin @(posedge clk); #1; end
    EX_MEM1Wr = 1'b1;
    flush     = flush_issue;
    @(posedge clk); #1;
    EX_MDOp = MD_NONE; EX_MEM1Wr = 1'b0; flush = 1'b0;
    EX_rs_data = '0; EX_rt_data = '0;
    sb_q.push_back(e);
    for (int c = 1; c <= 200 && sb_q.size() != 0; c++) begin
      if (c == flush_at) flush = 1'b1;
      if (c == rst_at)   rst   = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      rst   = 1'b0;
    end
    check({name, ".drain"}, 64'(sb_q.size()), 64'd0);
    if (sb_q.size() != 0) sb_q.delete();
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: counts busy cycles and compares whenever an op resolves
  initial begin
    bit   prev_busy = 1'b0;
    int   busy_cnt  = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
        busy_cnt  = 0;
      end else if (isbusy) begin
        busy_cnt++;
        check("no_op_while_busy", 64'(EX_MDOp), 64'(MD_NONE));
      end else if (prev_busy || (sb_q.size() != 0 && sb_q[0].busy == 0)) begin
        if (sb_q.size() == 0) begin
          check("unexpected_completion", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check({e.name, ".hi"}, 64'(HI), 64'(e.hi));
          check({e.name, ".lo"}, 64'(LO), 64'(e.lo));
          if (e.busy >= 0) check({e.name, ".busy"}, 64'(busy_cnt), 64'(e.busy));
        end
        busy_cnt = 0;
      end
      prev_busy = isbusy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    rst = 1'b1; EX_MDOp = MD_NONE; EX_MEM1Wr = 1'b0; flush = 1'b0;
    EX_rs_data = '0; EX_rt_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset.isbusy", 64'(isbusy), 64'd0);
    check("reset.hi", 64'(HI), 64'd0);
    check("reset.lo", 64'(LO), 64'd0);

    // Directed cases
    run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
    run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, "multu_neg2x3");
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, "div_neg7_2");
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_min_neg1");
    run_op(MD_DIVU,  32'd5, 32'd0, "divu_5_0");
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd0, "div_neg7_0");
    run_op(MD_DIV,   32'd9, 32'd0, "div_9_0");
    run_op(MD_MTHI,  32'h1234, 32'd0, "mthi_1234");
    run_op(MD_DIV,   32'd100, 32'd7, "div_flush_issue", 0, 1'b1);
    run_op(MD_DIV,   32'd100, 32'd7, "div_held3", 3);
    run_op(MD_DIVU,  32'hDEAD_BEEF, 32'h1234, "divu_flush_mid", 0, 1'b0, 10);
    run_op(MD_DIV,   32'h7FFF_FFFF, 32'd3, "div_rst_mid", 0, 1'b0, -1, 5);
    run_op(MD_MTHI,  32'h0, 32'd0, "mthi_0");
    run_op(MD_MTLO,  32'hFFFF_FFFF, 32'd0, "mtlo_ffff");
    run_op(MD_MADDU, 32'd1, 32'd1, "maddu_1x1");
    run_op(MD_MSUB,  32'hFFFF_FFFF, 32'd5, "msub_neg1x5");

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 10));
      run_op(op, rand_operand(), rand_operand(), $sformatf("rand%0d_op%0d", i, op),
             $urandom_range(0, 1));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
